chirp_symbol_scheduler: RTL and testbench

//  Sequences the serial slope-multiply datapath (symbol x slope) for the chirp transmitter.

---
 rtl/chirp_pkg.sv | 15 +
 rtl/chirp_sym_fifo.sv | 58 +++++
 rtl/chirp_symbol_scheduler.sv | 175 +++++++++++++++++
 tb/tb_chirp_symbol_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chirp_pkg.sv
// Shared definitions for the chirp symbol scheduler: datapath widths and
// the scheduler FSM state encoding.
package chirp_pkg;

    localparam int SYM_W   = 8;
    localparam int SLOPE_W = 32;

    typedef logic [1:0] sched_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/chirp_sym_fifo.sv
// Synchronous symbol FIFO, DEPTH x SYM_W, with full/empty flags.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset (empties the FIFO)
//   i_push, i_data   write a symbol (ignored while full)
//   i_pop            drop the head entry (ignored while empty)
//   o_head           current head entry
//   o_full, o_empty  occupancy flags decoded from the count register
module chirp_sym_fifo
    import chirp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [SYM_W-1:0] i_data,
    input  logic             i_pop,
    output logic [SYM_W-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SYM_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;
    assign o_head  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/chirp_symbol_scheduler.sv
// Chirp symbol scheduler: buffers 8-bit symbols, issues one active-low start
// pulse per symbol to the serial slope-multiply datapath together with the
// slope sampled from a shadow register, waits for the active-low done pulse
// and presents the product as a 32-bit frequency offset on valid/ready.
//
//   state | meaning
//   IDLE  | nothing in flight, waiting for a buffered symbol
//   ISSUE | start pulse low, symbol and slope presented to datapath
//   WAIT  | datapath busy, timeout counter running
//   HOLD  | offset valid, waiting for downstream ready
//
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_sym_valid, i_sym, o_sym_ready   symbol input handshake
//   i_slope_we, i_slope_cfg           slope shadow register write
//   o_acc_start_n, o_acc_symbol,
//   o_acc_slope                       datapath command
//   i_acc_done_n, i_acc_value         datapath completion
//   o_off_valid, o_offset, i_off_ready offset output handshake
//   o_busy                            FSM active or FIFO not empty
//   o_err_timeout, i_err_clr          sticky WAIT timeout flag and its clear
module chirp_symbol_scheduler
    import chirp_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 300
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sym_valid,
    input  logic [SYM_W-1:0]   i_sym,
    output logic               o_sym_ready,
    input  logic               i_slope_we,
    input  logic [SLOPE_W-1:0] i_slope_cfg,
    output logic               o_acc_start_n,
    output logic [SYM_W-1:0]   o_acc_symbol,
    output logic [SLOPE_W-1:0] o_acc_slope,
    input  logic               i_acc_done_n,
    input  logic [SLOPE_W-1:0] i_acc_value,
    output logic               o_off_valid,
    output logic [SLOPE_W-1:0] o_offset,
    input  logic               i_off_ready,
    output logic               o_busy,
    output logic               o_err_timeout,
    input  logic               i_err_clr
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    sched_state_t       state_q,    state_d;
    logic [SLOPE_W-1:0] shadow_q;
    logic               start_n_q,  start_n_d;
    logic [SYM_W-1:0]   sym_q,      sym_d;
    logic [SLOPE_W-1:0] slope_q,    slope_d;
    logic               valid_q,    valid_d;
    logic [SLOPE_W-1:0] offset_q,   offset_d;
    logic               err_q,      err_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic [SYM_W-1:0]   fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               issue_next;
    logic               timeout_hit;

    assign fifo_push = i_sym_valid & ~fifo_full;

    chirp_sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_data  (i_sym),
        .i_pop   (fifo_pop),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // The ISSUE-cycle outputs (start low, symbol, slope) are loaded on the
    // edge that enters ISSUE so that they appear registered during ISSUE.
    always_comb begin
        state_d     = state_q;
        start_n_d   = 1'b1;
        sym_d       = sym_q;
        slope_d     = slope_q;
        valid_d     = valid_q;
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;
        issue_next  = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) issue_next = 1'b1;
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done wins over a timeout landing in the same cycle.
                if (!i_acc_done_n) begin
                    offset_d = i_acc_value;
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (i_off_ready) begin
                    valid_d = 1'b0;
                    if (!fifo_empty) issue_next = 1'b1;
                    else             state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_next) begin
            state_d   = ST_ISSUE;
            fifo_pop  = 1'b1;
            sym_d     = fifo_head;
            slope_d   = shadow_q;
            start_n_d = 1'b0;
        end

        err_d = timeout_hit | (err_q & ~i_err_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            start_n_q <= 1'b1;
            sym_q     <= '0;
            slope_q   <= '0;
            valid_q   <= 1'b0;
            offset_q  <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            start_n_q <= start_n_d;
            sym_q     <= sym_d;
            slope_q   <= slope_d;
            valid_q   <= valid_d;
            offset_q  <= offset_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            if (i_slope_we) shadow_q <= i_slope_cfg;
        end
    end

    assign o_sym_ready   = ~fifo_full;
    assign o_acc_start_n = start_n_q;
    assign o_acc_symbol  = sym_q;
    assign o_acc_slope   = slope_q;
    assign o_off_valid   = valid_q;
    assign o_offset      = offset_q;
    assign o_err_timeout = err_q;
    assign o_busy        = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_chirp_symbol_scheduler.sv
// Directed bench for chirp_symbol_scheduler with a behavioural serial
// slope-multiply datapath: a symbol N completes N cycles after its start.
module tb_chirp_symbol_scheduler;

    logic        clk;
    logic        rst_n;
    logic        sym_valid;
    logic [7:0]  sym;
    logic        sym_ready;
    logic        slope_we;
    logic [31:0] slope_cfg;
    logic        acc_start_n;
    logic [7:0]  acc_symbol;
    logic [31:0] acc_slope;
    logic        acc_done_n;
    logic [31:0] acc_value;
    logic        off_valid;
    logic [31:0] offset;
    logic        off_ready;
    logic        busy;
    logic        err_timeout;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    chirp_symbol_scheduler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sym_valid   (sym_valid),
        .i_sym         (sym),
        .o_sym_ready   (sym_ready),
        .i_slope_we    (slope_we),
        .i_slope_cfg   (slope_cfg),
        .o_acc_start_n (acc_start_n),
        .o_acc_symbol  (acc_symbol),
        .o_acc_slope   (acc_slope),
        .i_acc_done_n  (acc_done_n),
        .i_acc_value   (acc_value),
        .o_off_valid   (off_valid),
        .o_offset      (offset),
        .i_off_ready   (off_ready),
        .o_busy        (busy),
        .o_err_timeout (err_timeout),
        .i_err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model; dp_dead freezes it mid-operation.
    logic        dp_dead;
    logic        dp_active;
    logic [7:0]  dp_rem;
    logic [31:0] dp_prod;

    assign acc_value = dp_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_done_n <= 1'b1;
            dp_active  <= 1'b0;
            dp_rem     <= 8'd0;
            dp_prod    <= 32'd0;
        end else begin
            acc_done_n <= 1'b1;
            if (!acc_start_n) begin
                dp_active <= 1'b1;
                dp_rem    <= acc_symbol;
                dp_prod   <= 32'(acc_symbol) * acc_slope;
            end else if (dp_active && !dp_dead) begin
                if (dp_rem <= 8'd1) begin
                    acc_done_n <= 1'b0;
                    dp_active  <= 1'b0;
                end else begin
                    dp_rem <= dp_rem - 8'd1;
                end
            end
        end
    end

    // Output monitor: accepted offsets, start-pulse cycles, full seen.
    logic [31:0] off_q [$];
    int          starts;
    logic        ready_low_seen;

    always @(negedge clk) begin
        if (rst_n) begin
            if (off_valid && off_ready) off_q.push_back(offset);
            if (!acc_start_n)           starts = starts + 1;
            if (!sym_ready)             ready_low_seen = 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_slope(input logic [31:0] v);
        slope_we  = 1'b1;
        slope_cfg = v;
        tick(1);
        slope_we  = 1'b0;
    endtask

    task automatic push_sym(input logic [7:0] s);
        int n;
        n = 0;
        sym_valid = 1'b1;
        sym       = s;
        while (!sym_ready && n < 2000) begin
            tick(1);
            n++;
        end
        if (n >= 2000) check_val("push_wait", 32'(n), 32'd0);
        tick(1);
        sym_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (acc_start_n && n < 1000);
        if (n >= 1000) check_val(tag, 32'(acc_start_n), 32'd0);
    endtask

    task automatic wait_offs(input string tag, input int cnt);
        int n;
        n = 0;
        while (off_q.size() < cnt && n < 3000) begin
            tick(1);
            n++;
        end
        check_val(tag, 32'(off_q.size()), 32'(cnt));
    endtask

    task automatic check_next_off(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        if (off_q.size() > 0) v = off_q.pop_front();
        check_val(tag, v, exp);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;

        rst_n          = 1'b0;
        sym_valid      = 1'b0;
        sym            = 8'd0;
        slope_we       = 1'b0;
        slope_cfg      = 32'd0;
        off_ready      = 1'b0;
        err_clr        = 1'b0;
        dp_dead        = 1'b0;
        starts         = 0;
        ready_low_seen = 1'b0;
        tick(3);

        check_val("rst_start_n", 32'(acc_start_n), 32'd1);
        check_val("rst_symbol",  32'(acc_symbol),  32'd0);
        check_val("rst_slope",   acc_slope,        32'd0);
        check_val("rst_valid",   32'(off_valid),   32'd0);
        check_val("rst_offset",  offset,           32'd0);
        check_val("rst_err",     32'(err_timeout), 32'd0);
        check_val("rst_ready",   32'(sym_ready),   32'd1);
        check_val("rst_busy",    32'(busy),        32'd0);

        rst_n = 1'b1;
        tick(2);

        // 1: single symbol
        off_ready = 1'b1;
        starts    = 0;
        set_slope(32'h0000_1000);
        push_sym(8'd3);
        check_val("t1_busy", 32'(busy), 32'd1);
        wait_start("t1_start_to");
        check_val("t1_acc_sym",   32'(acc_symbol), 32'd3);
        check_val("t1_acc_slope", acc_slope,       32'h0000_1000);
        wait_offs("t1_count", 1);
        check_next_off("t1_off", 32'h0000_3000);
        tick(5);
        check_val("t1_starts", 32'(starts), 32'd1);
        check_val("t1_idle",   32'(busy),   32'd0);

        // 2: back-to-back burst fills the FIFO
        starts         = 0;
        ready_low_seen = 1'b0;
        set_slope(32'h10);
        push_sym(8'd1);
        push_sym(8'd0);
        push_sym(8'd255);
        push_sym(8'd2);
        push_sym(8'd4);
        push_sym(8'd5);
        wait_offs("t2_count", 6);
        check_next_off("t2_off0", 32'h10);
        check_next_off("t2_off1", 32'h0);
        check_next_off("t2_off2", 32'hFF0);
        check_next_off("t2_off3", 32'h20);
        check_next_off("t2_off4", 32'h40);
        check_next_off("t2_off5", 32'h50);
        check_val("t2_full_seen", 32'(ready_low_seen), 32'd1);
        tick(5);
        check_val("t2_starts", 32'(starts), 32'd6);

        // 3: slope change during WAIT does not touch the in-flight symbol
        set_slope(32'd5);
        push_sym(8'd200);
        wait_start("t3_start_to");
        tick(1);
        set_slope(32'd7);
        check_val("t3_slope_held", acc_slope, 32'd5);
        push_sym(8'd1);
        wait_offs("t3_count", 2);
        check_next_off("t3_off0", 32'd1000);
        check_next_off("t3_off1", 32'd7);
        tick(5);

        // 4: downstream stalls in HOLD
        off_ready = 1'b0;
        starts    = 0;
        set_slope(32'd3);
        push_sym(8'd10);
        push_sym(8'd20);
        n = 0;
        while (!off_valid && n < 500) begin
            tick(1);
            n++;
        end
        check_val("t4_valid", 32'(off_valid), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (offset !== 32'd30 || off_valid !== 1'b1) bad++;
        end
        #1;
        check_val("t4_stable_bad", 32'(bad),    32'd0);
        check_val("t4_no_start",   32'(starts), 32'd1);
        check_val("t4_none_taken", 32'(off_q.size()), 32'd0);
        tick(1);
        off_ready = 1'b1;
        wait_offs("t4_count", 2);
        check_next_off("t4_off0", 32'd30);
        check_next_off("t4_off1", 32'd60);
        tick(5);

        // 5: datapath never completes
        dp_dead = 1'b1;
        starts  = 0;
        push_sym(8'd9);
        wait_start("t5_start_to");
        n = 0;
        while (!err_timeout && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_timeout_cyc", 32'(n), 32'd301);
        tick(5);
        check_val("t5_sticky",   32'(err_timeout),  32'd1);
        check_val("t5_no_valid", 32'(off_q.size()), 32'd0);
        check_val("t5_idle",     32'(busy),         32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check_val("t5_cleared", 32'(err_timeout), 32'd0);
        // Releasing the stub makes it emit a late done for sym 9.
        dp_dead = 1'b0;
        tick(20);
        check_val("t5_late_done", 32'(off_q.size()), 32'd0);
        check_val("t5_late_valid", 32'(off_valid),   32'd0);
        check_val("t5_starts",    32'(starts),       32'd1);

        // 6: async reset mid-WAIT with a symbol queued behind
        starts = 0;
        set_slope(32'd2);
        push_sym(8'd100);
        wait_start("t6_start_to");
        tick(10);
        push_sym(8'd50);
        tick(3);
        check_val("t6_busy_pre", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("t6_start_n", 32'(acc_start_n), 32'd1);
        check_val("t6_symbol",  32'(acc_symbol),  32'd0);
        check_val("t6_slope",   acc_slope,        32'd0);
        check_val("t6_valid",   32'(off_valid),   32'd0);
        check_val("t6_offset",  offset,           32'd0);
        check_val("t6_err",     32'(err_timeout), 32'd0);
        check_val("t6_ready",   32'(sym_ready),   32'd1);
        check_val("t6_busy",    32'(busy),        32'd0);
        tick(3);
        rst_n  = 1'b1;
        starts = 0;
        tick(300);
        check_val("t6_no_start",  32'(starts),       32'd0);
        check_val("t6_no_offset", 32'(off_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
